// File: rtl/poly_mult_ctrl_pkg.sv
// poly_mult_ctrl_pkg
//   Shared definitions for the poly_mult sequencer:
//   - state_e       : sequencer FSM states
//   - LFSR_W        : LFSR width
//   - LFSR_TAPS     : Galois tap mask for x^16+x^14+x^13+x^11+1
//   - DUMMY_REP     : LFSR copies forming a 128-bit dummy operand ({8{lfsr}})
//   - dummy_rep()   : copies needed to cover an arbitrary operand width
//   - lfsr_next()   : one Galois LFSR step
//   Optional feature macro used by the sequencer: POLY_MULT_DUMMY_EN.
package poly_mult_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_ACK  = 3'd2,
    ST_RUN  = 3'd3,
    ST_DONE = 3'd4,
    ST_ERR  = 3'd5
  } state_e;

  localparam int          LFSR_W    = 16;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam int          DUMMY_REP = 8;

  // Number of LFSR copies needed to fill a dummy operand of the given width.
  function automatic int dummy_rep(input int width);
    if (width == DUMMY_REP * LFSR_W) begin
      return DUMMY_REP;
    end
    return (width + LFSR_W - 1) / LFSR_W;
  endfunction

  // Right-shifting Galois step: the bit shifted out selects the tap mask.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

endpackage

// File: rtl/poly_mult_ctrl_lfsr.sv
// poly_mult_ctrl_lfsr
//   Free-running 16-bit Galois LFSR, advances every clock.
//   Ports:
//     clk     in   clock, rising edge
//     resetn  in   asynchronous active-low reset (loads pSEED)
//     lfsr_o  out  current LFSR state
//   Instantiated by poly_mult_ctrl only when POLY_MULT_DUMMY_EN is defined.
module poly_mult_ctrl_lfsr
  import poly_mult_ctrl_pkg::*;
#(
  parameter logic [15:0] pSEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        resetn,
  output logic [15:0] lfsr_o
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  always_comb begin
    lfsr_d = lfsr_next(lfsr_q);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lfsr_q <= pSEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign lfsr_o = lfsr_q;

endmodule

// File: rtl/poly_mult_ctrl.sv
// poly_mult_ctrl
//   Sequencer between the register block and the poly_mult core. Accepts a
//   start, issues load pulses to the core, follows its busy handshake,
//   captures the real result and reports done/busy/trigger. With
//   POLY_MULT_DUMMY_EN defined the real operation is hidden among a random
//   number of dummy operations; a watchdog aborts a hung core.
//   Ports:
//     clk, resetn        clock / asynchronous active-low reset
//     start_i            start request, level sampled in IDLE
//     key_i, data_i      key and operand, captured on accepted start
//     mult_load_o        one-cycle load pulse to the core
//     mult_key_o         captured key to the core
//     mult_data_o        operand to the core (real or dummy)
//     mult_data_i        core result
//     mult_busy_i        core busy
//     result_o           captured real result
//     done_o             one-cycle completion pulse
//     busy_o             high from accepted start until the done cycle
//     trigger_o          scope trigger, high across all operations
//     timeout_o          sticky watchdog flag, cleared on next start
//     dummy_cnt_o        {n_post, n_pre} of the current/last run
//     dbg_state_o        current FSM state (state_e encoding)
//   Macro: POLY_MULT_DUMMY_EN enables the LFSR and dummy insertion.
module poly_mult_ctrl #(
  parameter int unsigned pKEY_WIDTH  = 128,
  parameter int unsigned pDATA_WIDTH = 128,
  parameter int unsigned pDUMMY_BITS = 3,
  parameter int unsigned pTO_BITS    = 16,
  parameter logic [15:0] pLFSR_SEED  = 16'hACE1
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     start_i,
  input  logic [pKEY_WIDTH-1:0]    key_i,
  input  logic [pDATA_WIDTH-1:0]   data_i,
  output logic                     mult_load_o,
  output logic [pKEY_WIDTH-1:0]    mult_key_o,
  output logic [pDATA_WIDTH-1:0]   mult_data_o,
  input  logic [pDATA_WIDTH-1:0]   mult_data_i,
  input  logic                     mult_busy_i,
  output logic [pDATA_WIDTH-1:0]   result_o,
  output logic                     done_o,
  output logic                     busy_o,
  output logic                     trigger_o,
  output logic                     timeout_o,
  output logic [2*pDUMMY_BITS-1:0] dummy_cnt_o,
  output logic [2:0]               dbg_state_o
);
  import poly_mult_ctrl_pkg::*;

  // Op index covers up to 2*(2^B-1)+1 operations.
  localparam int IDX_W = pDUMMY_BITS + 1;
  localparam logic [pTO_BITS-1:0] TO_LAST = {{(pTO_BITS-1){1'b1}}, 1'b0};

  state_e                   state_q, state_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [pKEY_WIDTH-1:0]    key_q, key_d;
  logic [pDATA_WIDTH-1:0]   data_q, data_d;
  logic [pDATA_WIDTH-1:0]   mdata_q, mdata_d;
  logic [pDATA_WIDTH-1:0]   result_q, result_d;
  logic                     timeout_q, timeout_d;
  logic [pTO_BITS-1:0]      wd_q, wd_d;

  logic                     start_acc;
  logic [pDUMMY_BITS-1:0]   n_pre, n_post, n_pre_new;
  logic [pDATA_WIDTH-1:0]   dummy_data;
  logic [IDX_W-1:0]         idx_nxt, last_idx;
  logic                     is_real, wd_hit;

  assign start_acc = (state_q == ST_IDLE) && start_i;

`ifdef POLY_MULT_DUMMY_EN
  localparam int REP_N = dummy_rep(int'(pDATA_WIDTH));

  logic [LFSR_W-1:0]        lfsr;
  logic [REP_N*LFSR_W-1:0]  rep;
  logic [pDUMMY_BITS-1:0]   n_pre_q, n_post_q;

  poly_mult_ctrl_lfsr #(
    .pSEED (pLFSR_SEED)
  ) u_lfsr (
    .clk    (clk),
    .resetn (resetn),
    .lfsr_o (lfsr)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      n_pre_q  <= '0;
      n_post_q <= '0;
    end else if (start_acc) begin
      n_pre_q  <= lfsr[pDUMMY_BITS-1:0];
      n_post_q <= lfsr[2*pDUMMY_BITS-1:pDUMMY_BITS];
    end
  end

  assign n_pre      = n_pre_q;
  assign n_post     = n_post_q;
  // The first operand is chosen on the start edge, before n_pre_q is valid.
  assign n_pre_new  = lfsr[pDUMMY_BITS-1:0];
  assign rep        = {REP_N{lfsr}};
  assign dummy_data = rep[pDATA_WIDTH-1:0];
`else
  assign n_pre      = '0;
  assign n_post     = '0;
  assign n_pre_new  = '0;
  assign dummy_data = '0;
`endif

  assign idx_nxt  = idx_q + 1'b1;
  assign last_idx = {1'b0, n_pre} + {1'b0, n_post};
  assign is_real  = (idx_q == {1'b0, n_pre});
  assign wd_hit   = (wd_q == TO_LAST);

  // Core handshake: mult_load_o is a single-cycle request with the operand
  // and key stable on mult_data_o/mult_key_o. The core acknowledges by
  // raising mult_busy_i and signals completion (result valid on mult_data_i)
  // by dropping it; the first cycle busy is sampled low after being high
  // ends the operation.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    key_d     = key_q;
    data_d    = data_q;
    mdata_d   = mdata_q;
    result_d  = result_q;
    timeout_d = timeout_q;
    wd_d      = wd_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          key_d     = key_i;
          data_d    = data_i;
          idx_d     = '0;
          timeout_d = 1'b0;
          mdata_d   = (n_pre_new == '0) ? data_i : dummy_data;
          state_d   = ST_LOAD;
        end
      end
      ST_LOAD: begin
        wd_d    = '0;
        state_d = ST_ACK;
      end
      ST_ACK: begin
        wd_d = wd_q + 1'b1;
        if (mult_busy_i) begin
          state_d = ST_RUN;
        end else if (wd_hit) begin
          // Flag and clear now so both are visible in the ERR/done cycle.
          timeout_d = 1'b1;
          result_d  = '0;
          state_d   = ST_ERR;
        end
      end
      ST_RUN: begin
        wd_d = wd_q + 1'b1;
        if (!mult_busy_i) begin
          if (is_real) begin
            result_d = mult_data_i;
          end
          if (idx_q == last_idx) begin
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_nxt;
            mdata_d = (idx_nxt == {1'b0, n_pre}) ? data_q : dummy_data;
            state_d = ST_LOAD;
          end
        end else if (wd_hit) begin
          timeout_d = 1'b1;
          result_d  = '0;
          state_d   = ST_ERR;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      ST_ERR: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      key_q     <= '0;
      data_q    <= '0;
      mdata_q   <= '0;
      result_q  <= '0;
      timeout_q <= 1'b0;
      wd_q      <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      key_q     <= key_d;
      data_q    <= data_d;
      mdata_q   <= mdata_d;
      result_q  <= result_d;
      timeout_q <= timeout_d;
      wd_q      <= wd_d;
    end
  end

  assign mult_load_o = (state_q == ST_LOAD);
  assign mult_key_o  = key_q;
  assign mult_data_o = mdata_q;
  assign result_o    = result_q;
  assign done_o      = (state_q == ST_DONE) || (state_q == ST_ERR);
  assign busy_o      = (state_q == ST_LOAD) || (state_q == ST_ACK) || (state_q == ST_RUN);
  assign trigger_o   = busy_o;
  assign timeout_o   = timeout_q;
  assign dummy_cnt_o = {n_post, n_pre};
  assign dbg_state_o = state_q;

endmodule
